// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the RAM model and mem_arbiter.
// slave is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;
  logic              dstall;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, dstall, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, dstall, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction fetch and data access onto one RAM port with retry/timeout.
// Optional ARB_PERF_CNT_EN adds saturating icnt/dcnt/stallcnt counters.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]  icnt,
  output logic [31:0]  dcnt,
  output logic [31:0]  stallcnt
`endif
);

  localparam int WAIT_W  = $clog2(TIMEOUT + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                drop_q, drop_d;
  logic                err_q, err_d;
  logic                starve_q, starve_d;
  logic [DATA_W-1:0]   iload_q, iload_d;
  logic [DATA_W-1:0]   dload_q, dload_d;

  logic                ihit_c, dhit_c, ren_c, wen_c, dreq_c, access_c, error_c;

  assign dreq_c   = bus.dREN | bus.dWEN;
  assign access_c = !drop_q && (bus.ramstate == RAM_ACCESS);
  assign error_c  = !drop_q && (bus.ramstate == RAM_ERROR);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    retry_d  = retry_q;
    wait_d   = wait_q;
    drop_d   = 1'b0;
    err_d    = err_q;
    starve_d = starve_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    ihit_c   = 1'b0;
    dhit_c   = 1'b0;
    ren_c    = 1'b0;
    wen_c    = 1'b0;

    case (state_q)
      IDLE: begin
        // A fetch overtakes pending data once after every data completion.
        if (bus.iREN && (starve_q || !dreq_c)) begin
          state_d  = INSTR;
          addr_d   = bus.iaddr;
          starve_d = 1'b0;
          retry_d  = '0;
          wait_d   = '0;
        end else if (dreq_c) begin
          state_d = DATA;
          addr_d  = bus.daddr;
          wdata_d = bus.dstore;
          wr_d    = bus.dWEN;
          retry_d = '0;
          wait_d  = '0;
        end
      end

      DATA, INSTR: begin
        if (!drop_q) begin
          ren_c = (state_q == INSTR) || !wr_q;
          wen_c = (state_q == DATA) && wr_q;
        end
        if (access_c) begin
          state_d = IDLE;
          if (state_q == DATA) begin
            starve_d = 1'b1;
            if (dreq_c) begin
              dhit_c = 1'b1;
              if (!wr_q) begin
                dload_d = bus.ramload;
              end
            end
          end else if (bus.iREN) begin
            ihit_c  = 1'b1;
            iload_d = bus.ramload;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (error_c) begin
            retry_d = retry_q + RETRY_W'(1);
            drop_d  = 1'b1;
          end
          if ((wait_d == WAIT_W'(TIMEOUT)) ||
              (error_c && (retry_d == RETRY_W'(MAX_RETRY)))) begin
            err_d   = 1'b1;
            state_d = IDLE;
            drop_d  = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      retry_q  <= '0;
      wait_q   <= '0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
      starve_q <= 1'b0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      retry_q  <= retry_d;
      wait_q   <= wait_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      starve_q <= starve_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
    end
  end

  assign bus.ramREN   = ren_c;
  assign bus.ramWEN   = wen_c;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = wdata_q;
  assign bus.ihit     = ihit_c;
  assign bus.dhit     = dhit_c;
  assign bus.iload    = iload_d;
  assign bus.dload    = dload_d;
  assign bus.dstall   = dreq_c & ~dhit_c;
  assign bus.err      = err_q;

`ifdef ARB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0] icnt_q, icnt_d, dcnt_q, dcnt_d, stallcnt_q, stallcnt_d;

  always_comb begin
    icnt_d     = ihit_c ? sat_inc(icnt_q) : icnt_q;
    dcnt_d     = dhit_c ? sat_inc(dcnt_q) : dcnt_q;
    stallcnt_d = (dreq_c & ~dhit_c) ? sat_inc(stallcnt_q) : stallcnt_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icnt_q     <= '0;
      dcnt_q     <= '0;
      stallcnt_q <= '0;
    end else begin
      icnt_q     <= icnt_d;
      dcnt_q     <= dcnt_d;
      stallcnt_q <= stallcnt_d;
    end
  end

  assign icnt     = icnt_q;
  assign dcnt     = dcnt_q;
  assign stallcnt = stallcnt_q;
`endif

endmodule
